// File: rtl/npu_log_dumper.sv
// npu_log_dumper: reads the event count and then every live entry of the core
// or memory logger through a single-outstanding snoop port, and streams the
// result out as ADDR_WIDTH-bit words over a valid/ready handshake.
// Stream layout: count word, then per entry id, addr, flags, data (LSW first).

typedef enum logic [1:0] {
    SNOOP_CORE      = 2'd0,
    SNOOP_MEM       = 2'd1,
    GET_CORE_EVENTS = 2'd2,
    GET_MEM_EVENTS  = 2'd3
} log_snoop_req_t;

module npu_log_dumper #(
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 32,
    parameter int CORE_LOG_SIZE = 512,
    parameter int MEM_LOG_SIZE  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  select_mem_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  snoop_valid_o,
    output log_snoop_req_t        snoop_request_o,
    output logic [ADDR_WIDTH-1:0] snoop_addr_o,
    input  logic                  cl_valid_i,
    input  logic [ADDR_WIDTH-1:0] cl_req_addr_i,
    input  logic [DATA_WIDTH-1:0] cl_req_data_i,
    input  logic [ADDR_WIDTH-1:0] cl_req_id_i,
    input  logic                  cl_req_is_write_i,
    input  logic                  cl_req_is_read_i,
    output logic                  dump_valid_o,
    output logic [ADDR_WIDTH-1:0] dump_data_o,
    output logic                  dump_last_o,
    input  logic                  dump_ready_i
);

    localparam int DATA_WORDS      = DATA_WIDTH / ADDR_WIDTH;
    localparam int WORDS_PER_ENTRY = DATA_WORDS + 3;
    localparam int WORD_W          = $clog2(WORDS_PER_ENTRY + 1);
    localparam int LOG_MAX         = (CORE_LOG_SIZE > MEM_LOG_SIZE) ? CORE_LOG_SIZE : MEM_LOG_SIZE;
    localparam int K_W             = $clog2(LOG_MAX + 1);

    localparam logic [ADDR_WIDTH-1:0] CORE_SIZE_A = ADDR_WIDTH'(CORE_LOG_SIZE);
    localparam logic [ADDR_WIDTH-1:0] MEM_SIZE_A  = ADDR_WIDTH'(MEM_LOG_SIZE);
    localparam logic [WORD_W-1:0]     LAST_WORD   = WORD_W'(WORDS_PER_ENTRY - 1);

    // Parameter sanity: data must split into whole words, logs wrap by masking.
    generate
        if ((DATA_WIDTH % ADDR_WIDTH) != 0) begin : g_bad_width
            $error("npu_log_dumper: DATA_WIDTH must be a multiple of ADDR_WIDTH");
        end
        if (((CORE_LOG_SIZE & (CORE_LOG_SIZE - 1)) != 0) ||
            ((MEM_LOG_SIZE & (MEM_LOG_SIZE - 1)) != 0)) begin : g_bad_size
            $error("npu_log_dumper: log sizes must be powers of two");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_CNT  = 3'd1,
        ST_WAIT_CNT = 3'd2,
        ST_SEND_CNT = 3'd3,
        ST_REQ_ENT  = 3'd4,
        ST_WAIT_ENT = 3'd5,
        ST_SEND_ENT = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic                  sel_mem_q, sel_mem_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [ADDR_WIDTH-1:0] ent_id_q, ent_id_d;
    logic [ADDR_WIDTH-1:0] ent_addr_q, ent_addr_d;
    logic [DATA_WIDTH-1:0] ent_data_q, ent_data_d;
    logic                  ent_rd_q, ent_rd_d;
    logic                  ent_wr_q, ent_wr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  snoop_valid_q, snoop_valid_d;
    log_snoop_req_t        snoop_request_q, snoop_request_d;
    logic [ADDR_WIDTH-1:0] snoop_addr_q, snoop_addr_d;
    logic                  dump_valid_q, dump_valid_d;
    logic [ADDR_WIDTH-1:0] dump_data_q, dump_data_d;
    logic                  dump_last_q, dump_last_d;

    logic                  xfer_s;
    logic [ADDR_WIDTH-1:0] size_s;
    logic                  cnt_over_s;
    logic [ADDR_WIDTH-1:0] cnt_n_s;
    logic [ADDR_WIDTH-1:0] cnt_base_s;
    logic [K_W-1:0]        k_next_s;
    logic                  more_s;
    logic [WORD_W-1:0]     word_inc_s;

    // Selects one stream word of a buffered entry: id, addr, flags, data LSW first.
    function automatic logic [ADDR_WIDTH-1:0] entry_word(
        input logic [WORD_W-1:0]     idx,
        input logic [ADDR_WIDTH-1:0] id,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] data,
        input logic                  rd,
        input logic                  wr
    );
        logic [ADDR_WIDTH-1:0] w;
        case (idx)
            WORD_W'(0): w = id;
            WORD_W'(1): w = addr;
            WORD_W'(2): w = {{(ADDR_WIDTH-2){1'b0}}, rd, wr};
            default:    w = data[(int'(idx) - 3) * ADDR_WIDTH +: ADDR_WIDTH];
        endcase
        return w;
    endfunction

    assign xfer_s     = dump_valid_q & dump_ready_i;
    assign size_s     = sel_mem_q ? MEM_SIZE_A : CORE_SIZE_A;
    assign cnt_over_s = (cl_req_id_i > size_s);
    assign cnt_n_s    = cnt_over_s ? size_s : cl_req_id_i;
    assign cnt_base_s = cnt_over_s ? (cl_req_id_i & (size_s - ADDR_WIDTH'(1))) : {ADDR_WIDTH{1'b0}};
    assign k_next_s   = k_q + K_W'(1);
    assign more_s     = (ADDR_WIDTH'(k_next_s) < n_q);
    assign word_inc_s = word_q + WORD_W'(1);

    // State and datapath registers; reset aborts any dump in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            sel_mem_q       <= 1'b0;
            n_q             <= {ADDR_WIDTH{1'b0}};
            base_q          <= {ADDR_WIDTH{1'b0}};
            k_q             <= {K_W{1'b0}};
            word_q          <= {WORD_W{1'b0}};
            ent_id_q        <= {ADDR_WIDTH{1'b0}};
            ent_addr_q      <= {ADDR_WIDTH{1'b0}};
            ent_data_q      <= {DATA_WIDTH{1'b0}};
            ent_rd_q        <= 1'b0;
            ent_wr_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            snoop_valid_q   <= 1'b0;
            snoop_request_q <= SNOOP_CORE;
            snoop_addr_q    <= {ADDR_WIDTH{1'b0}};
            dump_valid_q    <= 1'b0;
            dump_data_q     <= {ADDR_WIDTH{1'b0}};
            dump_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sel_mem_q       <= sel_mem_d;
            n_q             <= n_d;
            base_q          <= base_d;
            k_q             <= k_d;
            word_q          <= word_d;
            ent_id_q        <= ent_id_d;
            ent_addr_q      <= ent_addr_d;
            ent_data_q      <= ent_data_d;
            ent_rd_q        <= ent_rd_d;
            ent_wr_q        <= ent_wr_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            snoop_valid_q   <= snoop_valid_d;
            snoop_request_q <= snoop_request_d;
            snoop_addr_q    <= snoop_addr_d;
            dump_valid_q    <= dump_valid_d;
            dump_data_q     <= dump_data_d;
            dump_last_q     <= dump_last_d;
        end
    end

    // Next-state logic: each request state lasts one cycle, send states wait on the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_REQ_CNT;
                else         state_d = ST_IDLE;
            end
            ST_REQ_CNT: state_d = ST_WAIT_CNT;
            ST_WAIT_CNT: begin
                if (cl_valid_i) state_d = ST_SEND_CNT;
                else            state_d = ST_WAIT_CNT;
            end
            ST_SEND_CNT: begin
                if (xfer_s) begin
                    if (n_q == {ADDR_WIDTH{1'b0}}) state_d = ST_DONE;
                    else                           state_d = ST_REQ_ENT;
                end else begin
                    state_d = ST_SEND_CNT;
                end
            end
            ST_REQ_ENT: state_d = ST_WAIT_ENT;
            ST_WAIT_ENT: begin
                if (cl_valid_i) state_d = ST_SEND_ENT;
                else            state_d = ST_WAIT_ENT;
            end
            ST_SEND_ENT: begin
                if (xfer_s && (word_q == LAST_WORD)) begin
                    if (more_s) state_d = ST_REQ_ENT;
                    else        state_d = ST_DONE;
                end else begin
                    state_d = ST_SEND_ENT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath updates; outputs are computed for the state being entered
    // so the registered copies line up with the state register.
    always_comb begin
        sel_mem_d       = sel_mem_q;
        n_d             = n_q;
        base_d          = base_q;
        k_d             = k_q;
        word_d          = word_q;
        ent_id_d        = ent_id_q;
        ent_addr_d      = ent_addr_q;
        ent_data_d      = ent_data_q;
        ent_rd_d        = ent_rd_q;
        ent_wr_d        = ent_wr_q;
        snoop_request_d = snoop_request_q;
        snoop_addr_d    = snoop_addr_q;
        dump_data_d     = dump_data_q;
        dump_last_d     = dump_last_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) sel_mem_d = select_mem_i;
                else         sel_mem_d = sel_mem_q;
            end
            ST_WAIT_CNT: begin
                if (cl_valid_i) begin
                    n_d         = cnt_n_s;
                    base_d      = cnt_base_s;
                    dump_data_d = cnt_n_s;
                    dump_last_d = (cnt_n_s == {ADDR_WIDTH{1'b0}});
                end else begin
                    n_d = n_q;
                end
            end
            ST_SEND_CNT: begin
                if (xfer_s) k_d = {K_W{1'b0}};
                else        k_d = k_q;
            end
            ST_WAIT_ENT: begin
                if (cl_valid_i) begin
                    ent_id_d    = cl_req_id_i;
                    ent_addr_d  = cl_req_addr_i;
                    ent_data_d  = cl_req_data_i;
                    ent_rd_d    = cl_req_is_read_i;
                    ent_wr_d    = cl_req_is_write_i;
                    word_d      = {WORD_W{1'b0}};
                    dump_data_d = cl_req_id_i;
                    dump_last_d = 1'b0;
                end else begin
                    word_d = word_q;
                end
            end
            ST_SEND_ENT: begin
                if (xfer_s) begin
                    if (word_q == LAST_WORD) begin
                        word_d = {WORD_W{1'b0}};
                        k_d    = k_next_s;
                    end else begin
                        word_d      = word_inc_s;
                        dump_data_d = entry_word(word_inc_s, ent_id_q, ent_addr_q,
                                                 ent_data_q, ent_rd_q, ent_wr_q);
                        dump_last_d = (word_inc_s == LAST_WORD) && !more_s;
                    end
                end else begin
                    word_d = word_q;
                end
            end
            default: begin
                word_d = word_q;
            end
        endcase

        // A request state is only ever entered, never held, so this fires once per request.
        if (state_d == ST_REQ_CNT) begin
            snoop_request_d = sel_mem_d ? GET_MEM_EVENTS : GET_CORE_EVENTS;
        end else if (state_d == ST_REQ_ENT) begin
            snoop_request_d = sel_mem_q ? SNOOP_MEM : SNOOP_CORE;
            snoop_addr_d    = (base_d + ADDR_WIDTH'(k_d)) & (size_s - ADDR_WIDTH'(1));
        end else begin
            snoop_request_d = snoop_request_q;
        end

        snoop_valid_d = (state_d == ST_REQ_CNT) || (state_d == ST_REQ_ENT);
        dump_valid_d  = (state_d == ST_SEND_CNT) || (state_d == ST_SEND_ENT);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign snoop_valid_o   = snoop_valid_q;
    assign snoop_request_o = snoop_request_q;
    assign snoop_addr_o    = snoop_addr_q;
    assign dump_valid_o    = dump_valid_q;
    assign dump_data_o     = dump_data_q;
    assign dump_last_o     = dump_last_q;

endmodule
